// File: rtl/temp_sample_source_if.sv
// Publish bus between the temperature sample source and the BCD display/monitor sink.
// Digits, the en strobe and the sign-change pulse travel together.
interface temp_sample_source_if;
   logic [3:0] temp_value_ones;
   logic [3:0] temp_value_tens;
   logic [3:0] temp_value_huns;
   logic       en;
   logic       mode;

   modport master (
      output temp_value_ones,
      output temp_value_tens,
      output temp_value_huns,
      output en,
      output mode
   );

   modport slave (
      input temp_value_ones,
      input temp_value_tens,
      input temp_value_huns,
      input en,
      input mode
   );
endinterface

// File: rtl/temp_sample_source.sv
// Periodic / on-demand temperature sampler: clamps to 999, converts to BCD with a
// serial double-dabble, then publishes the digits with a one-cycle en strobe.
module temp_sample_source #(
   parameter int BIN_W  = 10,
   parameter int PERIOD = 50000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BIN_W-1:0]     raw_temp,
   input  logic                 raw_sign,
   input  logic                 sample_now,
   temp_sample_source_if.master pub,
   output logic                 busy,
   output logic                 saturated,
   output logic                 overrun
);

   localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int STEP_W = $clog2(BIN_W);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(PERIOD - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);
   localparam logic [31:0]       BCD_MAX   = 32'd999;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      PUBLISH
   } state_t;

   state_t              state_q;
   logic [TICK_W-1:0]   tickCount_q;
   logic [TICK_W-1:0]   tickCount_d;
   logic [STEP_W-1:0]   step_q;
   logic [BIN_W-1:0]    bin_q;
   logic [BIN_W-1:0]    bin_d;
   logic [11:0]         bcd_q;
   logic [11:0]         bcd_d;
   logic [11:0]         adjusted;
   logic                sign_q;
   logic                lastSign_q;
   logic [3:0]          ones_q;
   logic [3:0]          tens_q;
   logic [3:0]          huns_q;
   logic                en_q;
   logic                mode_q;
   logic                busy_q;
   logic                saturated_q;
   logic                overrun_q;
   logic                tick;
   logic                trigger;
   logic                overLimit;
   logic [BIN_W-1:0]    clampedTemp;

   always_comb begin
      tick        = (tickCount_q == LAST_TICK);
      tickCount_d = tick ? '0 : tickCount_q + 1'b1;
      trigger     = tick | sample_now;
      overLimit   = (32'(raw_temp) > BCD_MAX);
      clampedTemp = overLimit ? BCD_MAX[BIN_W-1:0] : raw_temp;
   end

   // One double-dabble step: correct every nibble >= 5, then shift in the next binary MSB.
   always_comb begin
      adjusted = bcd_q;
      for (int d = 0; d < 3; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            adjusted[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end
      end
      bcd_d = 12'({adjusted, bin_q[BIN_W-1]});
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tickCount_q <= '0;
         step_q      <= '0;
         bin_q       <= '0;
         bcd_q       <= '0;
         sign_q      <= 1'b0;
         lastSign_q  <= 1'b0;
         ones_q      <= 4'd0;
         tens_q      <= 4'd0;
         huns_q      <= 4'd0;
         en_q        <= 1'b0;
         mode_q      <= 1'b0;
         busy_q      <= 1'b0;
         saturated_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         tickCount_q <= tickCount_d;
         en_q        <= 1'b0;
         mode_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  bin_q   <= clampedTemp;
                  sign_q  <= raw_sign;
                  bcd_q   <= '0;
                  step_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CONVERT;
                  if (overLimit) begin
                     saturated_q <= 1'b1;
                  end
               end
            end
            CONVERT: begin
               bcd_q  <= bcd_d;
               bin_q  <= bin_d;
               step_q <= step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  state_q <= PUBLISH;
               end
               if (trigger) begin
                  overrun_q <= 1'b1;
               end
            end
            PUBLISH: begin
               // Digits and en move on the same edge so the sink never sees a torn value.
               ones_q     <= bcd_q[3:0];
               tens_q     <= bcd_q[7:4];
               huns_q     <= bcd_q[11:8];
               en_q       <= 1'b1;
               mode_q     <= sign_q ^ lastSign_q;
               lastSign_q <= sign_q;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
               if (trigger) begin
                  overrun_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pub.temp_value_ones = ones_q;
   assign pub.temp_value_tens = tens_q;
   assign pub.temp_value_huns = huns_q;
   assign pub.en              = en_q;
   assign pub.mode            = mode_q;
   assign busy                = busy_q;
   assign saturated           = saturated_q;
   assign overrun             = overrun_q;

endmodule
